// File: rtl/gray_code_pkg.sv
// gray_code_pkg
// Shared constants and helpers for the gray-code adder pipeline.
//   DEFAULT_WIDTH / DEFAULT_STEP_WIDTH : default operand and step widths
//   GRAY_MAX_WIDTH                     : widest operand the helpers accept
//   bin2gray / gray2bin                : conversions on zero-extended values;
//                                        callers cast their WIDTH-bit value up
//                                        and the result back down
//   popcount                           : number of set bits, used by the
//                                        optional self-checker
// Optional feature macro used by the top: GRAY_CODE_SELF_CHECK_EN.
package gray_code_pkg;

    localparam int DEFAULT_WIDTH      = 32;
    localparam int DEFAULT_STEP_WIDTH = 8;
    localparam int GRAY_MAX_WIDTH     = 64;

    // Zero upper bits encode to zero, so a narrow value cast up to
    // GRAY_MAX_WIDTH converts correctly and truncates back losslessly.
    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
        input logic [GRAY_MAX_WIDTH-1:0] bin
    );
        return bin ^ (bin >> 1);
    endfunction

    // Running XOR from the MSB down; zero upper bits leave the prefix
    // unaffected, which keeps this width-generic.
    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(
        input logic [GRAY_MAX_WIDTH-1:0] gray
    );
        logic [GRAY_MAX_WIDTH-1:0] bin;
        logic                      acc;
        bin = '0;
        acc = 1'b0;
        for (int i = GRAY_MAX_WIDTH - 1; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
        return bin;
    endfunction

    function automatic int popcount(input logic [GRAY_MAX_WIDTH-1:0] value);
        int count;
        count = 0;
        for (int i = 0; i < GRAY_MAX_WIDTH; i++) begin
            count = count + int'(value[i]);
        end
        return count;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// gray_to_bin
// Combinational gray-to-binary decoder (XOR prefix from the MSB down).
//   WIDTH : operand width
//   gray  : gray-coded input
//   bin   : binary-coded output
module gray_to_bin
    import gray_code_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // A scalar accumulator carries the prefix so the output vector never
    // feeds back into itself inside the block.
    always_comb begin
        logic acc;
        acc = 1'b0;
        bin = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
    end

endmodule

// File: rtl/gray_code_adder_pipe.sv
// gray_code_adder_pipe
// Two-stage pipeline that adds or subtracts an unsigned binary step to a
// gray-coded operand and returns the gray-coded result plus carry/borrow.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   : input handshake (in_ready never depends on in_valid)
//   in_gray, in_step      : gray operand, unsigned binary step magnitude
//   in_sub                : 0 = add, 1 = subtract
//   out_valid / out_ready : output handshake; outputs hold while stalled
//   out_gray, out_wrap    : gray result, carry-out (add) or borrow-out (sub)
//   check_error           : sticky self-check flag
// Optional feature macro: GRAY_CODE_SELF_CHECK_EN. When defined, every
// stage-2 load is re-decoded and compared, and +1 steps are checked for a
// single-bit gray change. When undefined, check_error is tied to 0.
module gray_code_adder_pipe
    import gray_code_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int STEP_WIDTH = DEFAULT_STEP_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_gray,
    input  logic [STEP_WIDTH-1:0] in_step,
    input  logic                  in_sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_gray,
    output logic                  out_wrap,
    output logic                  check_error
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_bin_q,   s1_bin_d;
    logic [WIDTH-1:0] s1_step_q,  s1_step_d;
    logic             s1_sub_q,   s1_sub_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_gray_q,  out_gray_d;
    logic             out_wrap_q,  out_wrap_d;

    logic             adv1, adv2, load2;
    logic [WIDTH-1:0] in_bin;
    logic [WIDTH:0]   res_ext;
    logic [WIDTH-1:0] res_bin, res_gray;
    logic             res_wrap;

    gray_to_bin #(.WIDTH(WIDTH)) u_in_dec (
        .gray (in_gray),
        .bin  (in_bin)
    );

    // Stage 2 moves when its slot is empty or being drained; stage 1 moves
    // whenever stage 2 can take its contents, so bubbles collapse.
    assign adv2     = !out_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign load2    = adv2 && s1_valid_q;
    assign in_ready = adv1;

    // One extra bit holds the carry; for subtraction the extra bit of the
    // (WIDTH+1)-bit difference is set exactly when step > operand.
    always_comb begin
        if (s1_sub_q) begin
            res_ext = {1'b0, s1_bin_q} - {1'b0, s1_step_q};
        end else begin
            res_ext = {1'b0, s1_bin_q} + {1'b0, s1_step_q};
        end
        res_bin  = res_ext[WIDTH-1:0];
        res_wrap = res_ext[WIDTH];
        res_gray = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(res_bin)));
    end

    // Next-state for both pipeline stages.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_bin_d    = s1_bin_q;
        s1_step_d   = s1_step_q;
        s1_sub_d    = s1_sub_q;
        out_valid_d = out_valid_q;
        out_gray_d  = out_gray_q;
        out_wrap_d  = out_wrap_q;
        if (adv1) begin
            s1_valid_d = in_valid;
            s1_bin_d   = in_bin;
            s1_step_d  = WIDTH'(in_step);
            s1_sub_d   = in_sub;
        end
        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_gray_d = res_gray;
                out_wrap_d = res_wrap;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_bin_q    <= '0;
            s1_step_q   <= '0;
            s1_sub_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_gray_q  <= '0;
            out_wrap_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_bin_q    <= s1_bin_d;
            s1_step_q   <= s1_step_d;
            s1_sub_q    <= s1_sub_d;
            out_valid_q <= out_valid_d;
            out_gray_q  <= out_gray_d;
            out_wrap_q  <= out_wrap_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_gray  = out_gray_q;
    assign out_wrap  = out_wrap_q;

`ifdef GRAY_CODE_SELF_CHECK_EN
    logic [WIDTH-1:0] s1_gray_q, s1_gray_d;
    logic [WIDTH-1:0] chk_bin;
    logic             check_error_q, check_error_d;

    gray_to_bin #(.WIDTH(WIDTH)) u_chk_dec (
        .gray (res_gray),
        .bin  (chk_bin)
    );

    // The operand gray code travels alongside stage 1 so a +1 step can be
    // checked for a single-bit change; any violation latches until reset.
    always_comb begin
        s1_gray_d     = s1_gray_q;
        check_error_d = check_error_q;
        if (adv1) begin
            s1_gray_d = in_gray;
        end
        if (load2) begin
            if (chk_bin != res_bin) begin
                check_error_d = 1'b1;
            end
            if (!s1_sub_q && (s1_step_q == WIDTH'(1)) &&
                (popcount(GRAY_MAX_WIDTH'(s1_gray_q ^ res_gray)) != 1)) begin
                check_error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_gray_q     <= '0;
            check_error_q <= 1'b0;
        end else begin
            s1_gray_q     <= s1_gray_d;
            check_error_q <= check_error_d;
        end
    end

    assign check_error = check_error_q;
`else
    assign check_error = 1'b0;
`endif

endmodule

// File: tb/tb_gray_code_adder_pipe.sv
// tb_gray_code_adder_pipe
// Drives a 32-bit and an 8-bit instance of gray_code_adder_pipe with the same
// handshake and step, each with its own operand. Expected results come from
// plain modular arithmetic on binary operands, pushed into a scoreboard queue
// on input acceptance and popped by an independent monitor on output transfer.
module tb_gray_code_adder_pipe;

    localparam int W  = 32;
    localparam int W8 = 8;
    localparam int SW = 8;

    logic          clock     = 1'b0;
    logic          reset     = 1'b1;
    logic          in_valid  = 1'b0;
    logic [W-1:0]  in_gray   = '0;
    logic [W8-1:0] in_gray8  = '0;
    logic [SW-1:0] in_step   = '0;
    logic          in_sub    = 1'b0;
    logic          out_ready = 1'b1;

    logic          in_ready, in_ready8;
    logic          out_valid, out_valid8;
    logic [W-1:0]  out_gray;
    logic [W8-1:0] out_gray8;
    logic          out_wrap, out_wrap8;
    logic          check_error, check_error8;

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;    // 0 = always ready, 1 = random, 2 = stalled

    typedef struct {
        logic [31:0] g32;
        logic        w32;
        logic [7:0]  g8;
        logic        w8;
        logic [31:0] in_g32;
        logic [7:0]  in_g8;
        bit          inc;
    } exp_t;

    exp_t sb_q[$];

    gray_code_adder_pipe #(.WIDTH(W), .STEP_WIDTH(SW)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_gray     (in_gray),
        .in_step     (in_step),
        .in_sub      (in_sub),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_gray    (out_gray),
        .out_wrap    (out_wrap),
        .check_error (check_error)
    );

    gray_code_adder_pipe #(.WIDTH(W8), .STEP_WIDTH(SW)) u_dut8 (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready8),
        .in_gray     (in_gray8),
        .in_step     (in_step),
        .in_sub      (in_sub),
        .out_valid   (out_valid8),
        .out_ready   (out_ready),
        .out_gray    (out_gray8),
        .out_wrap    (out_wrap8),
        .check_error (check_error8)
    );

    always #5 clock = ~clock;

    // Gray code by definition: each bit is the XOR of neighbouring binary bits.
    function automatic longint unsigned to_gray(input longint unsigned v);
        return v ^ (v >> 1);
    endfunction

    // Reference arithmetic modulo 2^w with carry / borrow.
    function automatic void model(input longint unsigned b, input longint unsigned step,
                                  input bit sub, input int w,
                                  output longint unsigned r, output bit wrap);
        longint unsigned modv;
        modv = 64'd1 << w;
        if (!sub) begin
            wrap = (b + step) >= modv;
            r    = (b + step) % modv;
        end else begin
            wrap = step > b;
            r    = (b + modv - step) % modv;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic applyStimulus(input longint unsigned b32, input longint unsigned b8,
                                 input int unsigned step, input bit sub);
        exp_t            e;
        longint unsigned r;
        bit              w;
        bit              done;
        in_gray  = 32'(to_gray(b32));
        in_gray8 = 8'(to_gray(b8));
        in_step  = SW'(step);
        in_sub   = sub;
        in_valid = 1'b1;
        model(b32, longint'(step), sub, W, r, w);
        e.g32    = 32'(to_gray(r));
        e.w32    = w;
        model(b8, longint'(step), sub, W8, r, w);
        e.g8     = 8'(to_gray(r));
        e.w8     = w;
        e.in_g32 = in_gray;
        e.in_g8  = in_gray8;
        e.inc    = (step == 1) && !sub;
        done     = 1'b0;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(negedge clock);
            if (in_ready) begin
                sb_q.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // out_ready pattern generator.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: in_ready expectation from occupancy, stall stability, and
    // scoreboard comparison on every output transfer.
    initial begin
        int          occ;
        bit          held;
        logic [31:0] held_g;
        logic [7:0]  held_g8;
        logic        held_w, held_w8;
        exp_t        e;
        occ  = 0;
        held = 1'b0;
        held_g = '0; held_g8 = '0; held_w = 1'b0; held_w8 = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                sb_q.delete();
                occ  = 0;
                held = 1'b0;
            end else begin
                checkOutput("in_ready", 32'(in_ready), 32'(!(occ == 2 && !out_ready)));
                checkOutput("in_ready8", 32'(in_ready8), 32'(in_ready));
                if (held) begin
                    checkOutput("stall_valid", 32'(out_valid), 32'd1);
                    checkOutput("stall_gray", out_gray, held_g);
                    checkOutput("stall_wrap", 32'(out_wrap), 32'(held_w));
                    checkOutput("stall_gray8", 32'(out_gray8), 32'(held_g8));
                    checkOutput("stall_wrap8", 32'(out_wrap8), 32'(held_w8));
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        checkOutput("unexpected_output", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        checkOutput("gray32", out_gray, e.g32);
                        checkOutput("wrap32", 32'(out_wrap), 32'(e.w32));
                        checkOutput("valid8", 32'(out_valid8), 32'd1);
                        checkOutput("gray8", 32'(out_gray8), 32'(e.g8));
                        checkOutput("wrap8", 32'(out_wrap8), 32'(e.w8));
                        if (e.inc) begin
                            checkOutput("hamming32", 32'($countones(out_gray ^ e.in_g32)), 32'd1);
                            checkOutput("hamming8", 32'($countones(out_gray8 ^ e.in_g8)), 32'd1);
                        end
                    end
                end
                held    = out_valid && !out_ready;
                held_g  = out_gray;
                held_w  = out_wrap;
                held_g8 = out_gray8;
                held_w8 = out_wrap8;
                occ = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
            end
        end
    end

    task automatic drain();
        for (int c = 0; c < 200 && sb_q.size() != 0; c++) begin
            @(posedge clock);
        end
        if (sb_q.size() != 0) begin
            checkOutput("drain_timeout", 32'(sb_q.size()), 32'd0);
        end
        #1;
    endtask

    initial begin
        longint unsigned base;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_gray", out_gray, 32'd0);
        checkOutput("reset_out_wrap", 32'(out_wrap), 32'd0);
        checkOutput("reset_check_error", 32'(check_error), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid8", 32'(out_valid8), 32'd0);
        @(posedge clock);
        #1;

        // Directed corner cases: +1, carry wrap, borrow wrap, big sub, zero step.
        applyStimulus(5, 5, 1, 1'b0);
        applyStimulus(64'hFFFF_FFFF, 255, 1, 1'b0);
        applyStimulus(0, 0, 1, 1'b1);
        applyStimulus(3, 3, 200, 1'b1);
        applyStimulus(3, 3, 0, 1'b1);
        applyStimulus(1234, 77, 0, 1'b0);
        applyStimulus(200, 55, 255, 1'b0);
        drain();

        // Random operands with idle gaps, downstream always ready.
        for (int i = 0; i < 200; i++) begin
            applyStimulus(longint'($urandom), longint'($urandom_range(0, 255)),
                          $urandom_range(0, 255), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock);
                #1;
            end
        end
        drain();

        // Random backpressure.
        ready_mode = 1;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(longint'($urandom), longint'($urandom_range(0, 255)),
                          $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        ready_mode = 0;
        drain();

        // Fill both stages under stall, then reset mid-stream.
        ready_mode = 2;
        @(posedge clock);
        #1;
        applyStimulus(100, 10, 7, 1'b0);
        applyStimulus(200, 20, 9, 1'b1);
        @(negedge clock);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset_check_error", 32'(check_error), 32'd0);
        ready_mode = 0;
        repeat (5) @(posedge clock);
        #1;

        // Increment sweep over consecutive values.
        base = longint'($urandom);
        for (int i = 0; i < 65535; i++) begin
            applyStimulus((base + longint'(i)) % (64'd1 << W), longint'($urandom_range(0, 255)),
                          1, 1'b0);
        end
        drain();

        checkOutput("final_check_error", 32'(check_error), 32'd0);
        checkOutput("final_check_error8", 32'(check_error8), 32'd0);
        checkOutput("final_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
